// File: rtl/seq_alu.sv
// Handshaked ALU: logic/arith/shift ops in one cycle, iterative shift-add MUL, registered NZCV.
// Latency: 1 cycle non-MUL, WIDTH+1 cycles MUL. Result is held while out_ready=0; in_ready follows out_ready in DONE.
module seq_alu #(
    parameter int WIDTH  = 64,
    parameter int MOVK_W = 16,
    parameter int SHW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic [3:0]       flags,
    output logic             busy
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    localparam logic [3:0]       OP_MUL = 4'b1011;
    localparam logic [SHW-1:0]   LAST   = SHW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] KMASK  = {WIDTH{1'b1}} >> (WIDTH - MOVK_W);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [3:0]       flags_q, flags_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;

    logic             accept;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] f_res;
    logic             f_c, f_v;

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_MUL);
    assign alu_out   = res_q;
    assign flags     = flags_q;

    assign sum_ext = {1'b0, a} + {1'b0, b};
    assign diff    = a - b;

    // Single-cycle datapath; MUL is handled by the FSM and never selects this result.
    always_comb begin
        f_res = '1;
        f_c   = 1'b0;
        f_v   = 1'b0;
        case (op_code)
            4'b0001: f_res = a & b;
            4'b0010: f_res = a | b;
            4'b0011: f_res = ~a;
            4'b0100: f_res = a;
            4'b0101: f_res = b;
            4'b0110: begin
                f_res = sum_ext[WIDTH-1:0];
                f_c   = sum_ext[WIDTH];
                f_v   = (a[WIDTH-1] == b[WIDTH-1]) && (f_res[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0111: begin
                f_res = diff;
                f_c   = (a >= b);
                f_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            4'b1000: f_res = (a & ~KMASK) | (b & KMASK);
            4'b1001: f_res = a << b[SHW-1:0];
            4'b1010: f_res = a >> b[SHW-1:0];
            default: f_res = '1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        flags_d = flags_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (op_code == OP_MUL) begin
                        a_d     = a;
                        b_d     = b;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_MUL;
                    end else begin
                        res_d   = f_res;
                        flags_d = {f_res[WIDTH-1], (f_res == '0), f_c, f_v};
                        state_d = S_DONE;
                    end
                end else if ((state_q == S_DONE) && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                // Multiplicand shifts left while multiplier bits are consumed from the LSB.
                acc_d = acc_q + (b_q[0] ? a_q : '0);
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    res_d   = acc_d;
                    flags_d = {acc_d[WIDTH-1], (acc_d == '0), 2'b00};
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            flags_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu at WIDTH=64 and WIDTH=32, checked against an arithmetic reference model.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  op_code = 4'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;

    logic        vld64 = 1'b0, ordy64 = 1'b0;
    logic        rdy64, ov64, busy64;
    logic [63:0] res64;
    logic [3:0]  flg64;

    logic        vld32 = 1'b0, ordy32 = 1'b0;
    logic        rdy32, ov32, busy32;
    logic [31:0] res32;
    logic [3:0]  flg32;

    int errors = 0;
    int checks = 0;
    int sel_w  = 64;

    logic        cur_ov, cur_busy, cur_rdy;
    logic [63:0] cur_res;
    logic [3:0]  cur_flg;

    assign cur_ov   = (sel_w == 64) ? ov64   : ov32;
    assign cur_busy = (sel_w == 64) ? busy64 : busy32;
    assign cur_rdy  = (sel_w == 64) ? rdy64  : rdy32;
    assign cur_res  = (sel_w == 64) ? res64  : {32'b0, res32};
    assign cur_flg  = (sel_w == 64) ? flg64  : flg32;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(64), .MOVK_W(16), .SHW(6)) dut (
        .clk(clk), .rst(rst), .in_valid(vld64), .in_ready(rdy64),
        .a(a), .b(b), .op_code(op_code),
        .out_valid(ov64), .out_ready(ordy64), .alu_out(res64), .flags(flg64), .busy(busy64)
    );

    seq_alu #(.WIDTH(32), .MOVK_W(16), .SHW(5)) dut32 (
        .clk(clk), .rst(rst), .in_valid(vld32), .in_ready(rdy32),
        .a(a[31:0]), .b(b[31:0]), .op_code(op_code),
        .out_valid(ov32), .out_ready(ordy32), .alu_out(res32), .flags(flg32), .busy(busy32)
    );

    function automatic logic signed [66:0] sx(input logic [63:0] x, input int w);
        if (w == 64) return $signed({{3{x[63]}}, x});
        return $signed({{35{x[31]}}, x[31:0]});
    endfunction

    // Reference: operands taken as w-bit numbers, signed overflow = true result not representable in w bits.
    function automatic void model(input int w, input logic [3:0] op, input logic [63:0] a_in,
                                  input logic [63:0] b_in, output logic [63:0] r, output logic [3:0] f);
        logic [63:0] mask, x, y;
        logic [64:0] full;
        logic signed [66:0] st;
        logic c, v;
        int sh;
        mask = (w == 64) ? '1 : ((64'h1 << w) - 64'h1);
        x = a_in & mask;
        y = b_in & mask;
        c = 1'b0;
        v = 1'b0;
        sh = int'(y % w);
        case (op)
            4'd1: r = x & y;
            4'd2: r = x | y;
            4'd3: r = ~x;
            4'd4: r = x;
            4'd5: r = y;
            4'd6: begin
                full = {1'b0, x} + {1'b0, y};
                r = full[63:0];
                c = full[w];
                st = sx(x, w) + sx(y, w);
                v = (st != sx(st[63:0] & mask, w));
            end
            4'd7: begin
                r = x - y;
                c = (x >= y);
                st = sx(x, w) - sx(y, w);
                v = (st != sx(st[63:0] & mask, w));
            end
            4'd8: r = (x & ~64'hFFFF) | (y & 64'hFFFF);
            4'd9: r = x << sh;
            4'd10: r = x >> sh;
            4'd11: r = x * y;
            default: r = '1;
        endcase
        r = r & mask;
        f = {r[w-1], (r == 64'b0), c, v};
    endfunction

    // Issues one op from IDLE, waits for its result (bounded), then retires it.
    task automatic do_op(input int w, input logic [3:0] op, input logic [63:0] av, input logic [63:0] bv,
                         output logic [63:0] r, output logic [3:0] f, output int lat,
                         output int busy_n, output int rdy_bad);
        sel_w = w;
        @(negedge clk);
        op_code = op; a = av; b = bv;
        if (w == 64) vld64 = 1'b1; else vld32 = 1'b1;
        @(negedge clk);
        vld64 = 1'b0; vld32 = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; op_code = 4'($urandom);
        lat = 1; busy_n = 0; rdy_bad = 0;
        while (!cur_ov && lat < 200) begin
            if (cur_busy) busy_n++;
            if (cur_busy && cur_rdy) rdy_bad++;
            @(negedge clk);
            lat++;
        end
        r = cur_res;
        f = cur_flg;
        if (w == 64) ordy64 = 1'b1; else ordy32 = 1'b1;
        @(negedge clk);
        ordy64 = 1'b0; ordy32 = 1'b0;
    endtask

    task automatic test_reset();
        sel_w = 64;
        repeat (3) @(negedge clk);
        checks++;
        if (ov64 !== 1'b0 || busy64 !== 1'b0 || res64 !== 64'b0 || flg64 !== 4'b0 || rdy64 !== 1'b1) begin
            errors++;
            $display("FAIL reset64: ov=%b busy=%b res=%h flags=%b rdy=%b, want 0 0 0 0000 1", ov64, busy64, res64, flg64, rdy64);
        end
        checks++;
        if (ov32 !== 1'b0 || busy32 !== 1'b0 || res32 !== 32'b0 || flg32 !== 4'b0 || rdy32 !== 1'b1) begin
            errors++;
            $display("FAIL reset32: ov=%b busy=%b res=%h flags=%b rdy=%b, want 0 0 0 0000 1", ov32, busy32, res32, flg32, rdy32);
        end
        rst = 1'b0;
    endtask

    task automatic test_add_sub();
        logic [63:0] r; logic [3:0] f; int lat, bn, rb;
        do_op(64, 4'd6, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, r, f, lat, bn, rb);
        checks++;
        if (r !== 64'h8000_0000_0000_0000 || f !== 4'b1001 || lat !== 1) begin
            errors++;
            $display("FAIL add_ovf: res=%h flags=%b lat=%0d, want 8000000000000000 1001 1", r, f, lat);
        end
        do_op(64, 4'd7, 64'd5, 64'd5, r, f, lat, bn, rb);
        checks++;
        if (r !== 64'd0 || f !== 4'b0110) begin
            errors++;
            $display("FAIL sub_eq: res=%h flags=%b, want 0 0110", r, f);
        end
        do_op(64, 4'd7, 64'd0, 64'd1, r, f, lat, bn, rb);
        checks++;
        if (r !== '1 || f !== 4'b1000) begin
            errors++;
            $display("FAIL sub_borrow: res=%h flags=%b, want ffffffffffffffff 1000", r, f);
        end
    endtask

    task automatic test_mul();
        logic [63:0] r; logic [3:0] f; int lat, bn, rb;
        do_op(64, 4'd11, 64'd3, 64'd5, r, f, lat, bn, rb);
        checks++;
        if (r !== 64'd15 || f !== 4'b0000 || lat !== 65 || bn !== 64 || rb !== 0) begin
            errors++;
            $display("FAIL mul_3x5: res=%0d flags=%b lat=%0d busy=%0d rdy_in_busy=%0d, want 15 0000 65 64 0", r, f, lat, bn, rb);
        end
        do_op(32, 4'd11, 64'hFFFF_FFFF, 64'hFFFF_FFFF, r, f, lat, bn, rb);
        checks++;
        if (r !== 64'd1 || f !== 4'b0000 || lat !== 33 || bn !== 32) begin
            errors++;
            $display("FAIL mul32_wrap: res=%h flags=%b lat=%0d busy=%0d, want 1 0000 33 32", r, f, lat, bn);
        end
    endtask

    task automatic test_hold();
        logic [63:0] r0, er; logic [3:0] f0, ef; int bad;
        sel_w = 64;
        @(negedge clk);
        op_code = 4'd6; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd2; vld64 = 1'b1;
        @(negedge clk);
        vld64 = 1'b0; a = '0; b = '0;
        r0 = res64; f0 = flg64;
        model(64, 4'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, er, ef);
        checks++;
        if (ov64 !== 1'b1 || r0 !== er || f0 !== ef) begin
            errors++;
            $display("FAIL hold_first: ov=%b res=%h flags=%b, want 1 %h %b", ov64, r0, f0, er, ef);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res64 !== r0 || flg64 !== f0 || ov64 !== 1'b1 || rdy64 !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL hold_stable: unstable cycles=%0d, want 0", bad);
        end
        op_code = 4'd6; a = 64'd100; b = 64'd23; vld64 = 1'b1; ordy64 = 1'b1;
        @(negedge clk);
        vld64 = 1'b0;
        checks++;
        if (ov64 !== 1'b1 || res64 !== 64'd123 || flg64 !== 4'b0000) begin
            errors++;
            $display("FAIL hold_next: ov=%b res=%0d flags=%b, want 1 123 0000", ov64, res64, flg64);
        end
        @(negedge clk);
        ordy64 = 1'b0;
    endtask

    task automatic test_reset_mid_mul();
        int stale;
        sel_w = 64;
        @(negedge clk);
        op_code = 4'd11; a = 64'd7; b = 64'd9; vld64 = 1'b1;
        @(negedge clk);
        vld64 = 1'b0;
        repeat (19) @(negedge clk);
        checks++;
        if (busy64 !== 1'b1) begin
            errors++;
            $display("FAIL mid_mul_busy: busy=%b, want 1", busy64);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ov64 !== 1'b0 || busy64 !== 1'b0 || rdy64 !== 1'b1 || res64 !== 64'b0 || flg64 !== 4'b0) begin
            errors++;
            $display("FAIL mid_mul_reset: ov=%b busy=%b rdy=%b res=%h flags=%b, want 0 0 1 0 0000", ov64, busy64, rdy64, res64, flg64);
        end
        stale = 0;
        ordy64 = 1'b1;
        repeat (80) begin
            @(negedge clk);
            if (ov64 || busy64) stale++;
        end
        ordy64 = 1'b0;
        checks++;
        if (stale !== 0) begin
            errors++;
            $display("FAIL mid_mul_stale: active cycles=%0d, want 0", stale);
        end
    endtask

    task automatic test_w32();
        logic [63:0] r; logic [3:0] f; int lat, bn, rb;
        do_op(32, 4'd8, 64'h1234_5678, 64'hABCD, r, f, lat, bn, rb);
        checks++;
        if (r !== 64'h1234_ABCD || f !== 4'b0000) begin
            errors++;
            $display("FAIL movk32: res=%h flags=%b, want 1234abcd 0000", r, f);
        end
        do_op(32, 4'd9, 64'd1, 64'd31, r, f, lat, bn, rb);
        checks++;
        if (r !== 64'h8000_0000 || f !== 4'b1000) begin
            errors++;
            $display("FAIL lsl32_31: res=%h flags=%b, want 80000000 1000", r, f);
        end
        do_op(32, 4'd15, 64'd3, 64'd4, r, f, lat, bn, rb);
        checks++;
        if (r !== 64'hFFFF_FFFF || f !== 4'b1000) begin
            errors++;
            $display("FAIL op1111_32: res=%h flags=%b, want ffffffff 1000", r, f);
        end
        do_op(32, 4'd10, 64'hDEAD_BEEF, 64'd32, r, f, lat, bn, rb);
        checks++;
        if (r !== 64'hDEAD_BEEF) begin
            errors++;
            $display("FAIL lsr32_by0: res=%h, want deadbeef", r);
        end
        do_op(64, 4'd9, 64'h0123_4567_89AB_CDEF, 64'h40, r, f, lat, bn, rb);
        checks++;
        if (r !== 64'h0123_4567_89AB_CDEF) begin
            errors++;
            $display("FAIL lsl64_by0: res=%h, want 0123456789abcdef", r);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] q_r[$];
        logic [3:0]  q_f[$];
        logic [63:0] er, av, bv;
        logic [3:0]  ef, op;
        int n, bad;
        n = 24; bad = 0;
        sel_w = 64;
        @(negedge clk);
        ordy64 = 1'b1;
        for (int i = 0; i <= n; i++) begin
            if (i > 0) begin
                er = q_r.pop_front();
                ef = q_f.pop_front();
                if (ov64 !== 1'b1 || res64 !== er || flg64 !== ef) bad++;
            end
            if (i < n) begin
                if (rdy64 !== 1'b1) bad++;
                do op = 4'($urandom_range(0, 15)); while (op == 4'd11);
                av = {$urandom, $urandom}; bv = {$urandom, $urandom};
                model(64, op, av, bv, er, ef);
                q_r.push_back(er); q_f.push_back(ef);
                op_code = op; a = av; b = bv; vld64 = 1'b1;
            end else begin
                vld64 = 1'b0;
            end
            @(negedge clk);
        end
        ordy64 = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL back_to_back: bad cycles=%0d, want 0", bad);
        end
    endtask

    task automatic test_random();
        logic [63:0] corner[4];
        logic [63:0] r, er, av, bv;
        logic [3:0]  f, ef, op;
        int lat, bn, rb, w, elat;
        corner[0] = 64'h0; corner[1] = '1; corner[2] = 64'h8000_0000_8000_0000; corner[3] = 64'h7FFF_FFFF_7FFF_FFFF;
        for (int i = 0; i < 160; i++) begin
            w  = (i % 2 == 0) ? 64 : 32;
            op = 4'($urandom_range(0, 15));
            av = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : {$urandom, $urandom};
            bv = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : {$urandom, $urandom};
            model(w, op, av, bv, er, ef);
            elat = (op == 4'd11) ? w + 1 : 1;
            do_op(w, op, av, bv, r, f, lat, bn, rb);
            checks++;
            if (r !== er || f !== ef || lat !== elat) begin
                errors++;
                $display("FAIL random w=%0d op=%0d a=%h b=%h: res=%h flags=%b lat=%0d, want %h %b %0d",
                         w, op, av, bv, r, f, lat, er, ef, elat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_hold();
        test_reset_mid_mul();
        test_w32();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
